axis_noc_link_tx: RTL and testbench
===================================

# axis_noc_link_tx

Single-clock transmitter that drives one NoC router input port from an AXI-Stream source using the router's credit-based link protocol (data/dest/is_tail/send forward, credit back). It tracks downstream buffer space with a credit counter initialised to the router's FLIT_BUFFER_DEPTH, and registers every outgoing flit. It freezes the destination for the whole packet (wormhole) and flags protocol violations with sticky error bits. It is the injection-side counterpart of the router input buffer, for SERIALIZATION_FACTOR = CLKCROSS_FACTOR = 1 endpoints that run on clk_noc.

## Interface
Parameters:
- FLIT_BUFFER_DEPTH, 8, depth of the downstream router input buffer; initial and maximum credit count
- TDATA_WIDTH, 128, AXIS data width; also the flit width
- TDEST_WIDTH, 4, AXIS tdest width
- TID_WIDTH, 2, AXIS tid width
- DEST_WIDTH, TDEST_WIDTH + TID_WIDTH, link dest width; packed {tid, tdest}
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width

Ports:
- clk  in  1  NoC clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- axis_in_tvalid  in  1  source flit valid
- axis_in_tready  out  1  transmitter accepts the flit this cycle
- axis_in_tdata  in  TDATA_WIDTH  flit payload
- axis_in_tlast  in  1  last flit of the packet
- axis_in_tid  in  TID_WIDTH  stream id
- axis_in_tdest  in  TDEST_WIDTH  destination endpoint
- data_out  out  TDATA_WIDTH  link flit data
- dest_out  out  DEST_WIDTH  link destination
- is_tail_out  out  1  link tail marker
- send_out  out  1  link flit valid, single-cycle qualifier
- credit_in  in  1  one buffer slot freed downstream (one pulse = one credit)
- credits_avail  out  CNT_WIDTH  current credit count
- err_credit_overflow  out  1  sticky: a credit arrived while the counter was full
- err_dest_change  out  1  sticky: {tid,tdest} changed inside a packet

## Operation
- fire = axis_in_tvalid & axis_in_tready.
- axis_in_tready = in_reset_n_q & (credits != 0). This is combinational from registers only and never depends on tvalid.
- in_reset_n_q is a flop that is 0 during reset and 1 on the first clock after deassertion. tready is therefore low during the first cycle after reset.
- Credit update: credits_next = credits - fire + credit_in.
  - Simultaneous fire and credit_in leaves the count unchanged.
  - credit_in with credits == FLIT_BUFFER_DEPTH and no fire: the count saturates at FLIT_BUFFER_DEPTH and err_credit_overflow sets.
  - Underflow is impossible because tready is gated on a nonzero count.
- Packet FSM, two states:
  - HEAD: the next accepted flit is a head. On fire, capture {tid,tdest} into dest_hold. If tlast is 0, go to BODY. If tlast is 1 (single-flit packet), stay in HEAD.
  - BODY: flits use dest_hold for dest_out. On fire with tlast = 1, return to HEAD. If a BODY fire has {tid,tdest} != dest_hold, set err_dest_change; the flit is still sent with dest_hold.
- Output register, updated every cycle:
  - send_out <= fire.
  - On fire: data_out <= tdata, is_tail_out <= tlast, dest_out <= (state == HEAD) ? {tid,tdest} : dest_hold.
  - When not firing, data/dest/is_tail hold their previous values.
- Sticky errors clear only on reset.

## Timing
- Reset values: send_out 0, is_tail_out 0, data_out 0, dest_out 0, axis_in_tready 0, credits_avail FLIT_BUFFER_DEPTH, both err_* 0, FSM in HEAD.
- Reset asserted mid-packet: the FSM returns to HEAD, credits return to FLIT_BUFFER_DEPTH, and any in-flight flit is dropped. The downstream router is reset in the same domain.
- Latency: a flit accepted in cycle N appears with send_out = 1 in cycle N+1.
- Throughput: 1 flit/cycle while credits > 0.
- A credit_in pulse in cycle N raises credits in cycle N+1, so tready can rise in cycle N+1 at the earliest.
- With credits = 1 and fire in cycle N, tready is 0 in cycle N+1 unless credit_in was also high in cycle N.

## Structure
- The shared package noc_link_pkg holds:
  - the credit counter width function;
  - the typedef for the FSM state (HEAD, BODY);
  - the packing function for {tid,tdest} into DEST_WIDTH.
- One sub-module, noc_credit_counter: saturating up/down counter with init value, decrement, increment, count, nonzero and overflow outputs. It is reused later by the receive-side shim.

## Test plan
- Reset release with FLIT_BUFFER_DEPTH = 8 and constant tvalid: tready is 0 for one cycle, then exactly 8 flits are accepted back-to-back, then tready is 0 and credits_avail = 0.
- Packet of 3 flits with tid = 1, tdest = 5, one credit_in per cycle: send_out high for 3 consecutive cycles, dest_out = 6'h15 on every flit, is_tail_out only on the third, credits stay at 8.
- Drain credits to 0, pulse credit_in once: tready is high for exactly one cycle after the pulse and one flit is sent.
- Fire and credit_in in the same cycle with credits = 1: credits stays 1 and tready stays high.
- Change tdest from 5 to 9 on the second flit of a packet: err_dest_change sets, dest_out stays at the head value, the flag persists after the packet ends.
- credit_in with credits = 8 and no traffic: err_credit_overflow sets and credits_avail stays 8. Then assert rst_n = 0 mid-packet: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the credit-based NoC link shims.
package noc_link_pkg;

    // Widest {tid,tdest} the packing helper supports; callers truncate to their DEST_WIDTH.
    localparam int MAX_DEST_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } link_state_e;

    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_DEST_WIDTH-1:0] pack_dest(
        input logic [MAX_DEST_WIDTH-1:0] tid,
        input logic [MAX_DEST_WIDTH-1:0] tdest,
        input int                        tdest_width
    );
        return (tid << tdest_width) | tdest;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating up/down credit counter with registered count, nonzero flag and
// sticky overflow flag (increment attempted while full without a decrement).
module noc_credit_counter
    import noc_link_pkg::*;
#(
    parameter int INIT_VAL  = 8,
    parameter int MAX_VAL   = 8,
    parameter int CNT_WIDTH = credit_cnt_width(MAX_VAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    input  logic                 dec,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 nonzero,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] INIT_CNT = CNT_WIDTH'(INIT_VAL);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_VAL);
    localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_next_s;
    logic                 nonzero_r;
    logic                 overflow_r;
    logic                 ovf_event_s;

    // Next count: simultaneous inc/dec cancel; inc saturates at MAX, dec holds at zero.
    always_comb begin
        count_next_s = count_r;
        ovf_event_s  = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (count_r == MAX_CNT) begin
                    ovf_event_s = 1'b1;
                end else begin
                    count_next_s = count_r + ONE_CNT;
                end
            end
            2'b01: begin
                if (count_r != ZERO_CNT) begin
                    count_next_s = count_r - ONE_CNT;
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // Count, nonzero and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= INIT_CNT;
            nonzero_r  <= (INIT_CNT != ZERO_CNT);
            overflow_r <= 1'b0;
        end else if (srst) begin
            count_r    <= INIT_CNT;
            nonzero_r  <= (INIT_CNT != ZERO_CNT);
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            nonzero_r  <= (count_next_s != ZERO_CNT);
            overflow_r <= overflow_r | ovf_event_s;
        end
    end

    assign count    = count_r;
    assign nonzero  = nonzero_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/axis_noc_link_tx.sv
// AXI-Stream to credit-based NoC link transmitter: registered flit output,
// wormhole destination freeze and sticky protocol error flags.
module axis_noc_link_tx
    import noc_link_pkg::*;
#(
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int TDATA_WIDTH       = 128,
    parameter int TDEST_WIDTH       = 4,
    parameter int TID_WIDTH         = 2,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axis_in_tvalid,
    output logic                   axis_in_tready,
    input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic                   axis_in_tlast,
    input  logic [TID_WIDTH-1:0]   axis_in_tid,
    input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
    output logic [TDATA_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    output logic [CNT_WIDTH-1:0]   credits_avail,
    output logic                   err_credit_overflow,
    output logic                   err_dest_change
);

    link_state_e            state_r;
    logic                   in_reset_n_r;
    logic                   credit_nonzero_s;
    logic                   fire_s;
    logic [DEST_WIDTH-1:0]  head_dest_s;
    logic [DEST_WIDTH-1:0]  dest_hold_r;
    logic [TDATA_WIDTH-1:0] data_r;
    logic [DEST_WIDTH-1:0]  dest_r;
    logic                   is_tail_r;
    logic                   send_r;
    logic                   err_dest_change_r;

    // tready depends only on registers so the source never sees a tvalid loop.
    assign axis_in_tready = in_reset_n_r & credit_nonzero_s;
    assign fire_s         = axis_in_tvalid & axis_in_tready;
    assign head_dest_s    = DEST_WIDTH'(pack_dest(MAX_DEST_WIDTH'(axis_in_tid),
                                                  MAX_DEST_WIDTH'(axis_in_tdest),
                                                  TDEST_WIDTH));

    noc_credit_counter #(
        .INIT_VAL  (FLIT_BUFFER_DEPTH),
        .MAX_VAL   (FLIT_BUFFER_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_credit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (1'b0),
        .dec      (fire_s),
        .inc      (credit_in),
        .count    (credits_avail),
        .nonzero  (credit_nonzero_s),
        .overflow (err_credit_overflow)
    );

    // Holds tready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reset_n_r <= 1'b0;
        end else begin
            in_reset_n_r <= 1'b1;
        end
    end

    // Packet FSM, destination freeze and the registered link outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_HEAD;
            dest_hold_r       <= {DEST_WIDTH{1'b0}};
            data_r            <= {TDATA_WIDTH{1'b0}};
            dest_r            <= {DEST_WIDTH{1'b0}};
            is_tail_r         <= 1'b0;
            send_r            <= 1'b0;
            err_dest_change_r <= 1'b0;
        end else begin
            send_r <= fire_s;
            if (fire_s) begin
                data_r    <= axis_in_tdata;
                is_tail_r <= axis_in_tlast;
                case (state_r)
                    ST_HEAD: begin
                        dest_r      <= head_dest_s;
                        dest_hold_r <= head_dest_s;
                        state_r     <= axis_in_tlast ? ST_HEAD : ST_BODY;
                    end
                    ST_BODY: begin
                        // A mid-packet destination change is flagged but never followed.
                        dest_r <= dest_hold_r;
                        if (head_dest_s != dest_hold_r) begin
                            err_dest_change_r <= 1'b1;
                        end
                        state_r <= axis_in_tlast ? ST_HEAD : ST_BODY;
                    end
                    default: begin
                        dest_r  <= head_dest_s;
                        state_r <= ST_HEAD;
                    end
                endcase
            end
        end
    end

    assign data_out        = data_r;
    assign dest_out        = dest_r;
    assign is_tail_out     = is_tail_r;
    assign send_out        = send_r;
    assign err_dest_change = err_dest_change_r;

endmodule

// File: tb/tb_axis_noc_link_tx.sv
// Directed bench for axis_noc_link_tx: a transaction-level model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_axis_noc_link_tx;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic [127:0] tdata = 128'd0;
    logic         tlast = 1'b0;
    logic [1:0]   tid = 2'd0;
    logic [3:0]   tdest = 4'd0;
    logic [127:0] data_out;
    logic [5:0]   dest_out;
    logic         is_tail_out;
    logic         send_out;
    logic         credit_in = 1'b0;
    logic [3:0]   credits_avail;
    logic         err_ovf;
    logic         err_dest;

    int checks = 0;
    int errors = 0;

    axis_noc_link_tx #(.FLIT_BUFFER_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .axis_in_tvalid      (tvalid),
        .axis_in_tready      (tready),
        .axis_in_tdata       (tdata),
        .axis_in_tlast       (tlast),
        .axis_in_tid         (tid),
        .axis_in_tdest       (tdest),
        .data_out            (data_out),
        .dest_out            (dest_out),
        .is_tail_out         (is_tail_out),
        .send_out            (send_out),
        .credit_in           (credit_in),
        .credits_avail       (credits_avail),
        .err_credit_overflow (err_ovf),
        .err_dest_change     (err_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: link state described as credits, packet membership and last sent flit.
    bit           m_started;
    int           m_credits;
    bit           m_in_pkt;
    int           m_hold;
    bit           m_send;
    logic [127:0] m_data;
    int           m_dest;
    bit           m_tail;
    bit           m_err_ovf;
    bit           m_err_dest;

    task automatic model_reset();
        m_started = 1'b0; m_credits = DEPTH; m_in_pkt = 1'b0; m_hold = 0;
        m_send = 1'b0; m_data = 128'd0; m_dest = 0; m_tail = 1'b0;
        m_err_ovf = 1'b0; m_err_dest = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit accept;
            int flit_dest;
            accept    = tvalid && m_started && (m_credits > 0);
            flit_dest = int'(tid) * 16 + int'(tdest);
            if (credit_in && !accept && m_credits == DEPTH) m_err_ovf = 1'b1;
            m_credits = m_credits - (accept ? 1 : 0) + (credit_in ? 1 : 0);
            if (m_credits > DEPTH) m_credits = DEPTH;
            m_send = accept;
            if (accept) begin
                if (!m_in_pkt) m_hold = flit_dest;
                else if (flit_dest != m_hold) m_err_dest = 1'b1;
                m_data   = tdata;
                m_dest   = m_hold;
                m_tail   = tlast;
                m_in_pkt = !tlast;
            end
            m_started = 1'b1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        check("tready",      128'(tready),        128'(m_started && m_credits != 0));
        check("credits",     128'(credits_avail), 128'(m_credits));
        check("send_out",    128'(send_out),      128'(m_send));
        check("data_out",    data_out,            m_data);
        check("dest_out",    128'(dest_out),      128'(m_dest));
        check("is_tail_out", 128'(is_tail_out),   128'(m_tail));
        check("err_ovf",     128'(err_ovf),       128'(m_err_ovf));
        check("err_dest",    128'(err_dest),      128'(m_err_dest));
    end

    task automatic step(input logic v, input logic [127:0] d, input logic l,
                        input logic [1:0] i, input logic [3:0] de, input logic cr);
        tvalid = v; tdata = d; tlast = l; tid = i; tdest = de; credit_in = cr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int sent;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_tready",  128'(tready),        128'd0);
        check("rst_credits", 128'(credits_avail), 128'd8);
        check("rst_send",    128'(send_out),      128'd0);
        check("rst_data",    data_out,            128'd0);
        check("rst_dest",    128'(dest_out),      128'd0);
        check("rst_errs",    128'({err_ovf, err_dest}), 128'd0);

        // Reset release with constant tvalid: one dead cycle, then exactly 8 flits.
        tvalid = 1'b1; tlast = 1'b1; tid = 2'd0; tdest = 4'd1;
        rst_n = 1'b1;
        #1;
        check("release_tready_low", 128'(tready), 128'd0);
        sent = 0;
        for (int k = 0; k < 12; k++) begin
            tdata = 128'(k + 100);
            @(posedge clk);
            #2;
            if (send_out) sent++;
            if (k == 0) check("first_edge_tready", 128'(tready), 128'd1);
        end
        check("burst_count", 128'(sent), 128'd8);
        check("burst_credits", 128'(credits_avail), 128'd0);
        check("burst_tready", 128'(tready), 128'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        check("refill", 128'(credits_avail), 128'd8);

        // 3-flit packet to tid=1,tdest=5 with a credit returned every cycle.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 128'hA000 + 128'(k), (k == 2), 2'd1, 4'd5, 1'b1);
            check("pkt_send", 128'(send_out), 128'd1);
            check("pkt_dest", 128'(dest_out), 128'h15);
            check("pkt_tail", 128'(is_tail_out), 128'(k == 2));
            check("pkt_credits", 128'(credits_avail), 128'd8);
        end
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        check("pkt_idle_send", 128'(send_out), 128'd0);

        // Drain to zero, then a single credit lets exactly one flit through.
        for (int k = 0; k < 8; k++) step(1'b1, 128'(k), 1'b1, 2'd0, 4'd2, 1'b0);
        check("drained", 128'(credits_avail), 128'd0);
        step(1'b1, 128'h77, 1'b1, 2'd0, 4'd2, 1'b1);
        check("one_credit_tready", 128'(tready), 128'd1);
        check("one_credit_nosend", 128'(send_out), 128'd0);
        step(1'b1, 128'h78, 1'b1, 2'd0, 4'd2, 1'b0);
        check("one_credit_send", 128'(send_out), 128'd1);
        check("one_credit_data", data_out, 128'h78);
        check("one_credit_tready_low", 128'(tready), 128'd0);
        step(1'b1, 128'h79, 1'b1, 2'd0, 4'd2, 1'b0);
        check("one_credit_only", 128'(send_out), 128'd0);

        // Fire and credit together at credits = 1.
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 128'hB0 + 128'(k), 1'b1, 2'd2, 4'd3, 1'b1);
            check("balance_send", 128'(send_out), 128'd1);
            check("balance_credits", 128'(credits_avail), 128'd1);
            check("balance_tready", 128'(tready), 128'd1);
        end
        for (int k = 0; k < 7; k++) step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        check("refill2", 128'(credits_avail), 128'd8);

        // tdest changes 5 -> 9 inside a packet.
        check("no_dest_err_yet", 128'(err_dest), 128'd0);
        step(1'b1, 128'hC0, 1'b0, 2'd1, 4'd5, 1'b0);
        step(1'b1, 128'hC1, 1'b0, 2'd1, 4'd9, 1'b0);
        check("dchg_err", 128'(err_dest), 128'd1);
        check("dchg_dest", 128'(dest_out), 128'h15);
        step(1'b1, 128'hC2, 1'b1, 2'd1, 4'd9, 1'b0);
        check("dchg_tail_dest", 128'(dest_out), 128'h15);
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        check("dchg_sticky", 128'(err_dest), 128'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b1);

        // Credit while full.
        check("no_ovf_yet", 128'(err_ovf), 128'd0);
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b1);
        check("ovf_err", 128'(err_ovf), 128'd1);
        check("ovf_credits", 128'(credits_avail), 128'd8);
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        check("ovf_sticky", 128'(err_ovf), 128'd1);

        // Asynchronous reset in the middle of a packet.
        step(1'b1, 128'hD0, 1'b0, 2'd2, 4'd3, 1'b0);
        check("mid_head_dest", 128'(dest_out), 128'h23);
        tvalid = 1'b1; tdata = 128'hD1; tdest = 4'd3;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_tready",  128'(tready),        128'd0);
        check("arst_credits", 128'(credits_avail), 128'd8);
        check("arst_send",    128'(send_out),      128'd0);
        check("arst_data",    data_out,            128'd0);
        check("arst_dest",    128'(dest_out),      128'd0);
        check("arst_tail",    128'(is_tail_out),   128'd0);
        check("arst_errs",    128'({err_ovf, err_dest}), 128'd0);
        repeat (2) @(posedge clk);
        #2;
        tvalid = 1'b1; tdata = 128'hE0; tlast = 1'b1; tid = 2'd3; tdest = 4'd7;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        check("post_rst_send", 128'(send_out), 128'd1);
        check("post_rst_head_dest", 128'(dest_out), 128'h37);
        check("post_rst_tail", 128'(is_tail_out), 128'd1);
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b0);
        step(1'b0, 128'd0, 1'b0, 2'd0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
